regfile_scoreboard: RTL

Parametrised successor to the 64-bit, 32-entry CPU register file. It has a configurable number of combinational read ports and one write port that commits on the rising edge. It adds same-cycle write-to-read bypass, an optional hardwired-zero register, and a per-register busy scoreboard that decode uses to detect read-after-write hazards. It sits between instruction decode (read addresses, reservations) and writeback (BusW/RW/RegWr) in the pipelined CPU.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/regfile_read_port.sv | 26 ++
 rtl/regfile_scoreboard.sv | 60 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file widths and shared types for decode and writeback
package cpu_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int ZERO_IDX = 31;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port's zero / bypass / array / busy selection
module regfile_read_port #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int ZERO_EN = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS_EN = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rw,
  input  logic              reg_wr,
  input  logic [DATA_W-1:0] bus_w,
  input  logic [DATA_W-1:0] array_data,
  input  logic              busy_bit,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] ZI = ADDR_W'(ZERO_IDX);
  logic is_zero, is_byp;
  always_comb begin
    is_zero = (ZERO_EN != 0) && (ra == ZI);
    is_byp = (BYPASS_EN != 0) && reg_wr && (rw == ra);
    data = is_zero ? '0 : is_byp ? bus_w : array_data;
    busy = !is_zero && !is_byp && busy_bit;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write bypass, hardwired zero and busy scoreboard
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NUM_RD = 2,
  parameter int ZERO_EN = 1,
  parameter int ZERO_IDX = cpu_pkg::ZERO_IDX,
  parameter int BYPASS_EN = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] BusR,
  output logic [NUM_RD-1:0]        Busy,
  input  logic [ADDR_W-1:0]        RW,
  input  logic [DATA_W-1:0]        BusW,
  input  logic                     RegWr,
  input  logic [ADDR_W-1:0]        RV,
  input  logic                     Rsv,
  output logic                     BusyAny
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZI = ADDR_W'(ZERO_IDX);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  // reserve is evaluated after write so a same-index reserve leaves busy set
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem <= '{default: '0};
      busy <= '0;
    end else begin
      if (RegWr && !((ZERO_EN != 0) && RW == ZI)) begin
        mem[RW] <= BusW;
        busy[RW] <= 1'b0;
      end
      if (Rsv && !((ZERO_EN != 0) && RV == ZI)) busy[RV] <= 1'b1;
    end
  end
  assign BusyAny = |busy;
  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_EN(ZERO_EN),
        .ZERO_IDX(ZERO_IDX), .BYPASS_EN(BYPASS_EN)
      ) u_port (
        .ra(RA[i*ADDR_W +: ADDR_W]),
        .rw(RW),
        .reg_wr(RegWr),
        .bus_w(BusW),
        .array_data(mem[RA[i*ADDR_W +: ADDR_W]]),
        .busy_bit(busy[RA[i*ADDR_W +: ADDR_W]]),
        .data(BusR[i*DATA_W +: DATA_W]),
        .busy(Busy[i])
      );
    end
  endgenerate
endmodule
